// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the RV32E load/store unit.
// Holds the RISC-V load/store funct3 codes, the FSM state encoding,
// the register-bus width and the unit identifier used when reporting
// an impossible FSM state.
package lsu_mem_stage_pkg;

  localparam int REG_BUS_W = 32;
  localparam int UNIT_LSU  = 3;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   we, funct3, off  - access kind, size code and byte offset addr[1:0]
//   wdata            - rs2 store data
//   rdata            - full memory read word
//   illegal          - access is misaligned or funct3 is not a valid load/store
//   wstrb, wdata_lane- byte strobes and lane-replicated store data (0 for loads)
//   rdata_ext        - selected and sign/zero-extended load result
module lsu_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              illegal,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        bs;
    logic signed [DATA_W-1:0] ws;
    bs = signed'(b);
    ws = DATA_W'(bs);
    return sgn ? ws : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       hs;
    logic signed [DATA_W-1:0] ws;
    hs = signed'(h);
    ws = DATA_W'(hs);
    return sgn ? ws : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*off +: 8];
  assign half_sel = rdata[16*off[1] +: 16];

  always_comb begin
    if (we) illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else    illegal = funct3 inside {3'b011, 3'b110, 3'b111};
    if ((funct3 == F3_LH || funct3 == F3_LHU) && off[0]) illegal = 1'b1;
    if (funct3 == F3_LW && off != 2'b00)                 illegal = 1'b1;
  end

  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = '0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          wstrb      = 4'b0001 << off;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_SH: begin
          wstrb      = 4'b0011 << off;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          wstrb      = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  // funct3[2] distinguishes the unsigned variants (LBU/LHU)
  always_comb begin
    case (funct3)
      F3_LB, F3_LBU: rdata_ext = ext8(byte_sel, !funct3[2]);
      F3_LH, F3_LHU: rdata_ext = ext16(half_sel, !funct3[2]);
      default:       rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32E load/store unit between execute and writeback.
// Accepts one access at a time, runs it over a valid/ready memory port
// and returns an extended load result or a store completion.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   req_valid/req_ready, req_we,   - access request from execute
//   req_funct3, req_addr,
//   req_wdata, req_rd
//   mem_valid/mem_ready, mem_addr, - word-aligned memory request
//   mem_we, mem_wstrb, mem_wdata
//   mem_rvalid, mem_rdata          - memory read return
//   resp_valid/resp_ready,         - result towards writeback; err flags
//   resp_data, resp_rd, resp_err     misaligned or illegal accesses
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err
);

  lsu_state_e        state;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_off;
  logic [RD_W-1:0]   lat_rd;

  logic [2:0]        align_f3;
  logic [1:0]        align_off;
  logic              illegal;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_ext;

  // In IDLE the lane logic looks at the live request (legality, store lanes);
  // afterwards it looks at the latched access so WAIT can extract read data.
  assign align_f3  = (state == ST_IDLE) ? req_funct3    : lat_f3;
  assign align_off = (state == ST_IDLE) ? req_addr[1:0] : lat_off;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .we         (req_we),
    .funct3     (align_f3),
    .off        (align_off),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .illegal    (illegal),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_ext)
  );

  // Access descriptor needed after acceptance; not part of the reset state.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      lat_f3  <= req_funct3;
      lat_off <= req_addr[1:0];
      lat_rd  <= req_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (illegal) begin
              // Faulting access never reaches memory
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_rd    <= req_we ? '0 : req_rd;
            end else begin
              state     <= ST_REQ;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_we    <= req_we;
              mem_wstrb <= lane_strb;
              mem_wdata <= lane_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= '0;
            if (mem_we) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= '0;
              resp_rd    <= '0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= load_ext;
            resp_rd    <= lat_rd;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding (UNIT_LSU abort case): recover to IDLE
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases followed by
// randomized accesses, each compared against a byte/size-level model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic [3:0]  resp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    return (a % access_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int     nb;
    longint v;
    longint span;
    nb   = access_bytes(f3);
    v    = 0;
    v[31:0] = word >> (8 * (a % 4));
    span = longint'(1) << (8 * nb);
    v    = v % span;
    if (!f3[2] && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] lane, output logic [3:0] strb);
    int nb;
    nb = access_bytes(f3);
    if (nb == 1)      lane = (d % 256) * 32'h0101_0101;
    else if (nb == 2) lane = (d % 65536) * 32'h0001_0001;
    else              lane = d;
    strb = 4'(((1 << nb) - 1) << (a % 4));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready,  1);
    check({tag, "_mem_valid"},  mem_valid,  0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_mem_wstrb"},  mem_wstrb,  0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"},  resp_data,  0);
    check({tag, "_resp_rd"},    resp_rd,    0);
    check({tag, "_resp_err"},   resp_err,   0);
  endtask

  // One complete access. ms: cycles mem_ready stays low, rvd: cycles in WAIT
  // before rvalid, rs: cycles resp_ready stays low, stray: rvalid during REQ.
  task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] rd, input logic [31:0] rdata,
                         input int ms, input int rvd, input int rs, input bit stray);
    bit          err;
    logic [31:0] e_data, e_lane;
    logic [3:0]  e_strb, e_rd;
    err    = model_illegal(we, f3, addr);
    e_data = (err || we) ? 32'd0 : model_load(f3, addr, rdata);
    e_rd   = we ? 4'd0 : rd;
    model_store(f3, addr, wdata, e_lane, e_strb);

    @(negedge clk);
    check({tag, "_idle_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk); #1;
    // Scramble the request bus so the DUT must rely on latched fields
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 4'($urandom);

    if (!err) begin
      for (int i = 0; i <= ms; i++) begin
        mem_ready  = (i == ms);
        mem_rvalid = stray && (i == 0);
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        check({tag, "_mem_valid"}, mem_valid, 1);
        check({tag, "_mem_addr"},  mem_addr,  {addr[31:2], 2'b00});
        check({tag, "_mem_we"},    mem_we,    we);
        if (we) begin
          check({tag, "_mem_wstrb"}, mem_wstrb, e_strb);
          check({tag, "_mem_wdata"}, mem_wdata, e_lane);
        end
        check({tag, "_early_resp"}, resp_valid, 0);
        @(posedge clk); #1;
      end
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (!we) begin
        for (int i = 0; i <= rvd; i++) begin
          mem_rvalid = (i == rvd);
          mem_rdata  = (i == rvd) ? rdata : $urandom;
          @(negedge clk);
          check({tag, "_wait_mem_valid"}, mem_valid, 0);
          check({tag, "_wait_resp"},      resp_valid, 0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end

    for (int i = 0; i <= rs; i++) begin
      resp_ready = (i == rs);
      @(negedge clk);
      check({tag, "_resp_valid"}, resp_valid, 1);
      check({tag, "_resp_data"},  resp_data,  e_data);
      check({tag, "_resp_rd"},    resp_rd,    e_rd);
      check({tag, "_resp_err"},   resp_err,   err);
      check({tag, "_resp_memv"},  mem_valid,  0);
      check({tag, "_resp_rdy"},   req_ready,  0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_single_resp"}, resp_valid, 0);
    check({tag, "_back_idle"},   req_ready,  1);
  endtask

  initial begin
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 4'd0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    resp_ready = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_txn("sw",  1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 4'd9, 32'd0,         0, 0, 0, 0);
    run_txn("lb",  0, 3'b000, 32'h8000_0003, 32'd0,         4'd5, 32'h8012_3456, 0, 0, 0, 0);
    run_txn("lbu", 0, 3'b100, 32'h8000_0003, 32'd0,         4'd5, 32'h8012_3456, 0, 0, 0, 0);
    run_txn("sh",  1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 4'd1, 32'd0,         0, 0, 0, 0);
    run_txn("lhu", 0, 3'b101, 32'h8000_0002, 32'd0,         4'd2, 32'hABCD_0000, 0, 0, 0, 0);
    run_txn("lh",  0, 3'b001, 32'h8000_0000, 32'd0,         4'd3, 32'h1234_8001, 0, 0, 0, 0);
    run_txn("lwmis", 0, 3'b010, 32'h8000_0002, 32'd0,       4'd4, 32'd0,         0, 0, 0, 0);
    run_txn("shmis", 1, 3'b001, 32'h8000_0001, 32'h1111,    4'd0, 32'd0,         0, 0, 0, 0);
    run_txn("ldbad", 0, 3'b110, 32'h8000_0000, 32'd0,       4'd6, 32'd0,         0, 0, 0, 0);
    run_txn("stbad", 1, 3'b100, 32'h8000_0000, 32'h55,      4'd0, 32'd0,         0, 0, 0, 0);
    run_txn("lwx0",  0, 3'b010, 32'h8000_0010, 32'd0,       4'd0, 32'hCAFE_F00D, 0, 0, 0, 0);
    run_txn("bp",    0, 3'b010, 32'h8000_0008, 32'd0,       4'd7, 32'h0BAD_F00D, 3, 1, 2, 1);
    run_txn("bpst",  1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 4'd0, 32'd0,       3, 0, 2, 1);

    // Reset while a load is waiting for read data
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h8000_0020;
    req_rd     = 4'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rstwait_in_wait", req_ready, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_resp",  resp_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    run_txn("after_rst", 0, 3'b001, 32'h8000_0022, 32'd0, 4'd11, 32'hF00F_1234, 1, 1, 0, 0);

    // Randomized accesses, mostly legal
    for (int n = 0; n < 40; n++) begin
      r_we = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (r_we) r_f3 = 3'($urandom_range(0, 2));
        else      r_f3 = (3'($urandom_range(0, 4)) == 3'd3) ? 3'd4 : 3'($urandom_range(0, 5));
        if (r_f3 == 3'd3) r_f3 = 3'd5;
        r_addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
        r_addr = r_addr | ((32'($urandom_range(0, 3)) / access_bytes(r_f3)) * access_bytes(r_f3));
      end else begin
        r_f3   = 3'($urandom);
        r_addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      end
      run_txn("rand", r_we, r_f3, r_addr, $urandom, 4'($urandom), $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
